// File: rtl/adc_sample_avg.sv
// -----------------------------------------------------------------------------
// adc_sample_avg
//
// Front-end averager between the external temperature ADC and the fan
// controller. The asynchronous conversion-ready level is brought into the clk_i
// domain through a three-flop chain. Each rising edge of that level yields one
// accept pulse, on which the ADC word is captured. A power-of-two window of
// samples is summed and the truncated mean is presented with a one-cycle
// data-valid strobe. A watchdog raises a sticky flag when the ADC stops
// delivering samples while a window is being collected.
//
// Ports:
//   clk_i            system clock, rising edge
//   rst_i            asynchronous active-high reset
//   enable_i         synchronous run enable; low returns the block to IDLE
//   adc_value_i      ADC conversion result, stable around the ready edge
//   adc_rdy_i        asynchronous conversion-done level from the ADC
//   avg_value_o      registered window mean
//   dataVaild_STRB_o one-cycle strobe, avg_value_o is new in this cycle
//   timeout_o        sticky watchdog flag, cleared by the next accepted sample
// -----------------------------------------------------------------------------
module adc_sample_avg #(
    parameter int ADC_BITWIDTH = 4,
    parameter int AVG_LOG2     = 2,
    parameter int TIMEOUT      = 100
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic [ADC_BITWIDTH-1:0] adc_value_i,
    input  logic                    adc_rdy_i,
    output logic [ADC_BITWIDTH-1:0] avg_value_o,
    output logic                    dataVaild_STRB_o,
    output logic                    timeout_o
);

    // The accumulator is wide enough to hold a full window of maximum-valued
    // samples, so the sum never wraps.
    localparam int ACC_W = ADC_BITWIDTH + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t            state, state_nxt;

    logic              rdy_sync1, rdy_sync2, rdy_sync3;
    logic              accept;

    logic [ACC_W-1:0]  acc, acc_nxt;
    logic [ACC_W-1:0]  sum;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [WD_W-1:0]   wd_cnt, wd_nxt;
    logic [ADC_BITWIDTH-1:0] avg_nxt;
    logic              strobe_nxt;
    logic              timeout_nxt;

    // Mean of a full window: plain right shift, fractional bits dropped.
    function automatic logic [ADC_BITWIDTH-1:0] trunc_mean(input logic [ACC_W-1:0] total);
        return ADC_BITWIDTH'(total >> AVG_LOG2);
    endfunction

    // Ready synchroniser, clocked in every state so the edge detector never
    // sees a stale level when the block is re-enabled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdy_sync1 <= 1'b0;
            rdy_sync2 <= 1'b0;
            rdy_sync3 <= 1'b0;
        end else begin
            rdy_sync1 <= adc_rdy_i;
            rdy_sync2 <= rdy_sync1;
            rdy_sync3 <= rdy_sync2;
        end
    end

    // One pulse per rising edge of the synchronised ready level. The data word
    // is sampled directly on this cycle: the ADC holds it stable long enough
    // that it has settled by the time the ready edge has crossed the chain.
    assign accept = rdy_sync2 & ~rdy_sync3;

    assign sum = acc + ACC_W'(adc_value_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= IDLE;
            acc              <= '0;
            cnt              <= '0;
            wd_cnt           <= '0;
            avg_value_o      <= '0;
            dataVaild_STRB_o <= 1'b0;
            timeout_o        <= 1'b0;
        end else begin
            state            <= state_nxt;
            acc              <= acc_nxt;
            cnt              <= cnt_nxt;
            wd_cnt           <= wd_nxt;
            avg_value_o      <= avg_nxt;
            dataVaild_STRB_o <= strobe_nxt;
            timeout_o        <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        cnt_nxt     = cnt;
        wd_nxt      = wd_cnt;
        avg_nxt     = avg_value_o;
        strobe_nxt  = 1'b0;
        timeout_nxt = timeout_o;

        unique case (state)
            IDLE: begin
                acc_nxt     = '0;
                cnt_nxt     = '0;
                wd_nxt      = '0;
                timeout_nxt = 1'b0;
                if (enable_i) begin
                    state_nxt = ACCUM;
                end
            end

            // EMIT lasts a single cycle but keeps collecting, so a sample that
            // lands while the strobe is up starts the next window.
            ACCUM, EMIT: begin
                if (state == EMIT) begin
                    state_nxt = ACCUM;
                end
                if (accept) begin
                    wd_nxt      = '0;
                    timeout_nxt = 1'b0;
                    if (cnt == LAST_CNT) begin
                        avg_nxt    = trunc_mean(sum);
                        strobe_nxt = 1'b1;
                        acc_nxt    = '0;
                        cnt_nxt    = '0;
                        state_nxt  = EMIT;
                    end else begin
                        acc_nxt = sum;
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end else if (state == ACCUM) begin
                    // Expiry discards the partial window but keeps collecting.
                    if (wd_cnt >= WD_LAST) begin
                        timeout_nxt = 1'b1;
                        acc_nxt     = '0;
                        cnt_nxt     = '0;
                        wd_nxt      = '0;
                    end else begin
                        wd_nxt = wd_cnt + WD_W'(1);
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Disable wins over everything; the strobe already registered for an
        // EMIT cycle still completes because it lives in its own flop.
        if (!enable_i) begin
            state_nxt   = IDLE;
            acc_nxt     = '0;
            cnt_nxt     = '0;
            wd_nxt      = '0;
            avg_nxt     = avg_value_o;
            strobe_nxt  = 1'b0;
            timeout_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_sample_avg.sv
// -----------------------------------------------------------------------------
// tb_adc_sample_avg
//
// Bench for adc_sample_avg with default parameters (4-bit samples, window of
// 4, watchdog 100 cycles). Each driven sample feeds a window model; completed
// windows push their truncated mean onto a queue which the output monitor pops
// whenever the strobe is seen.
// -----------------------------------------------------------------------------
module tb_adc_sample_avg;

    localparam int ADC_BITWIDTH = 4;
    localparam int AVG_LOG2     = 2;
    localparam int TIMEOUT      = 100;
    localparam int WINDOW       = 1 << AVG_LOG2;

    logic                    clk_i;
    logic                    rst_i;
    logic                    enable_i;
    logic [ADC_BITWIDTH-1:0] adc_value_i;
    logic                    adc_rdy_i;
    logic [ADC_BITWIDTH-1:0] avg_value_o;
    logic                    dataVaild_STRB_o;
    logic                    timeout_o;

    adc_sample_avg #(
        .ADC_BITWIDTH(ADC_BITWIDTH),
        .AVG_LOG2    (AVG_LOG2),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .enable_i        (enable_i),
        .adc_value_i     (adc_value_i),
        .adc_rdy_i       (adc_rdy_i),
        .avg_value_o     (avg_value_o),
        .dataVaild_STRB_o(dataVaild_STRB_o),
        .timeout_o       (timeout_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc            = 0;
    int rise_cyc       = 0;
    int last_strobe_cyc = -1;
    int strobe_cnt     = 0;

    int model_sum = 0;
    int model_cnt = 0;
    bit model_on  = 1'b0;
    int exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        model_sum = 0;
        model_cnt = 0;
    endtask

    always @(posedge clk_i) cyc++;

    // Output monitor, sampling on the falling edge.
    always @(negedge clk_i) begin
        if (!rst_i && dataVaild_STRB_o === 1'b1) begin
            strobe_cnt++;
            last_strobe_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {31'd0, dataVaild_STRB_o}, 32'd0);
            end else begin
                check("avg_value", {28'd0, avg_value_o}, exp_q.pop_front());
            end
        end
    end

    // One ready pulse: high for hi cycles, low for lo cycles; the data word
    // stays on the bus until the next call.
    task automatic send_sample(input int v, input int hi, input int lo);
        @(posedge clk_i);
        #1;
        adc_value_i = v[ADC_BITWIDTH-1:0];
        adc_rdy_i   = 1'b1;
        rise_cyc    = cyc;
        if (model_on) begin
            model_sum += v;
            model_cnt++;
            if (model_cnt == WINDOW) begin
                exp_q.push_back(model_sum >> AVG_LOG2);
                model_clear();
            end
        end
        repeat (hi) @(posedge clk_i);
        #1;
        adc_rdy_i = 1'b0;
        repeat (lo) @(posedge clk_i);
    endtask

    int s0;
    int basic_vals[4]  = '{3, 5, 7, 9};
    int trunc_vals[8]  = '{15, 15, 15, 14, 0, 0, 0, 1};
    int post_vals[4]   = '{2, 4, 6, 8};

    initial begin
        rst_i       = 1'b1;
        enable_i    = 1'b0;
        adc_value_i = '0;
        adc_rdy_i   = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_avg",     {28'd0, avg_value_o},      32'd0);
        check("reset_strobe",  {31'd0, dataVaild_STRB_o}, 32'd0);
        check("reset_timeout", {31'd0, timeout_o},        32'd0);
        rst_i = 1'b0;

        // Basic window 3,5,7,9 -> 6, strobe three edges after the last rise.
        enable_i = 1'b1;
        model_on = 1'b1;
        @(posedge clk_i);
        s0 = strobe_cnt;
        for (int i = 0; i < 3; i++) send_sample(basic_vals[i], 3, 3);
        check("basic_no_early_strobe", strobe_cnt - s0, 0);
        send_sample(basic_vals[3], 3, 3);
        check("basic_strobe_count", strobe_cnt - s0, 1);
        check("basic_latency", last_strobe_cyc - rise_cyc, 3);

        // Enable drop discards 12,12; mean holds while disabled.
        s0 = strobe_cnt;
        send_sample(12, 3, 3);
        send_sample(12, 3, 3);
        @(posedge clk_i);
        #1;
        enable_i = 1'b0;
        model_clear();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("disabled_avg_hold", {28'd0, avg_value_o}, 32'd6);
        end
        enable_i = 1'b1;
        for (int i = 0; i < 4; i++) send_sample(4, 3, 3);
        check("enable_strobe_count", strobe_cnt - s0, 1);

        // Truncation and back-to-back windows at tight spacing: 14 then 0.
        s0 = strobe_cnt;
        for (int i = 0; i < 8; i++) send_sample(trunc_vals[i], 1, 2);
        repeat (4) @(posedge clk_i);
        check("b2b_strobe_count", strobe_cnt - s0, 2);

        // Held ready counts once; three further pulses complete the window.
        s0 = strobe_cnt;
        send_sample(10, 50, 3);
        check("held_single_accept", strobe_cnt - s0, 0);
        for (int i = 0; i < 3; i++) send_sample(10, 3, 3);
        check("held_strobe_count", strobe_cnt - s0, 1);

        // Pulses while disabled are ignored.
        @(posedge clk_i);
        #1;
        enable_i = 1'b0;
        model_on = 1'b0;
        s0 = strobe_cnt;
        for (int i = 0; i < 5; i++) send_sample(10, 2, 3);
        check("disabled_no_strobe", strobe_cnt - s0, 0);
        enable_i = 1'b1;
        model_on = 1'b1;
        model_clear();
        repeat (2) @(posedge clk_i);

        // Watchdog: 8,8 then silence; the partial window is discarded.
        s0 = strobe_cnt;
        send_sample(8, 3, 3);
        send_sample(8, 3, 3);
        repeat (80) @(posedge clk_i);
        @(negedge clk_i);
        check("timeout_not_yet", {31'd0, timeout_o}, 32'd0);
        repeat (30) @(posedge clk_i);
        @(negedge clk_i);
        check("timeout_set", {31'd0, timeout_o}, 32'd1);
        check("timeout_no_strobe", strobe_cnt - s0, 0);
        model_clear();
        send_sample(1, 3, 0);
        @(negedge clk_i);
        check("timeout_cleared", {31'd0, timeout_o}, 32'd0);
        for (int i = 0; i < 3; i++) send_sample(1, 3, 3);
        repeat (4) @(posedge clk_i);
        check("timeout_window_strobe", strobe_cnt - s0, 1);

        // Watchdog again, then asynchronous reset between clock edges.
        send_sample(9, 3, 3);
        send_sample(9, 3, 3);
        repeat (110) @(posedge clk_i);
        @(negedge clk_i);
        check("timeout_set_again", {31'd0, timeout_o}, 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_avg",     {28'd0, avg_value_o},      32'd0);
        check("async_rst_strobe",  {31'd0, dataVaild_STRB_o}, 32'd0);
        check("async_rst_timeout", {31'd0, timeout_o},        32'd0);
        model_clear();
        repeat (2) @(posedge clk_i);
        #2;
        rst_i = 1'b0;

        // After reset a complete fresh window is required: 2,4,6,8 -> 5.
        s0 = strobe_cnt;
        for (int i = 0; i < 3; i++) send_sample(post_vals[i], 3, 3);
        check("post_rst_no_early", strobe_cnt - s0, 0);
        send_sample(post_vals[3], 3, 3);
        check("post_rst_strobe_count", strobe_cnt - s0, 1);
        check("post_rst_latency", last_strobe_cyc - rise_cyc, 3);

        repeat (4) @(posedge clk_i);
        check("pending_expected", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
